// File: rtl/fifo_pkg.sv
// Shared helpers and default sizing for the fifo_stream buffer.
package fifo_pkg;

    localparam int unsigned DefDataSize    = 8;
    localparam int unsigned DefAddressSize = 3;
    localparam int unsigned DefAeThresh    = 2;

    function automatic int unsigned fifo_depth(input int unsigned address_size);
        return 32'd1 << address_size;
    endfunction

    function automatic int unsigned fifo_clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset on contents.
module fifo_ram import fifo_pkg::*; #(
    parameter int unsigned DATA_SIZE    = DefDataSize,
    parameter int unsigned ADDRESS_SIZE = DefAddressSize
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDRESS_SIZE-1:0] waddr,
    input  logic [DATA_SIZE-1:0]    wdata,
    input  logic [ADDRESS_SIZE-1:0] raddr,
    output logic [DATA_SIZE-1:0]    rdata
);

    localparam int unsigned DEPTH = fifo_depth(ADDRESS_SIZE);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_stream.sv
// First-word-fall-through FIFO with valid/ready on both sides, fill level, threshold flags,
// sticky overflow/underflow and synchronous flush.
module fifo_stream import fifo_pkg::*; #(
    parameter int unsigned DATA_SIZE    = DefDataSize,
    parameter int unsigned ADDRESS_SIZE = DefAddressSize,
    parameter int unsigned AF_THRESH    = fifo_depth(ADDRESS_SIZE) - 2,
    parameter int unsigned AE_THRESH    = DefAeThresh
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    err_clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_SIZE-1:0]    in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_SIZE-1:0]    out_data,
    output logic [ADDRESS_SIZE:0]   level,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned DEPTH = fifo_depth(ADDRESS_SIZE);

    typedef logic [ADDRESS_SIZE:0]   level_t;
    typedef logic [ADDRESS_SIZE-1:0] ptr_t;

    localparam level_t LvlFull = level_t'(DEPTH);
    localparam level_t LvlAf   = level_t'(AF_THRESH);
    localparam level_t LvlAe   = level_t'(AE_THRESH);

    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
        $error("fifo_stream: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
    end

    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    level_t level_q, level_d;
    logic   overflow_q, overflow_d;
    logic   underflow_q, underflow_d;
    logic   wr_fire, rd_fire;
    logic [DATA_SIZE-1:0] ram_rdata;

    // Every flag decodes from the registered level; pointer equality is never consulted.
    always_comb begin
        full         = (level_q == LvlFull);
        empty        = (level_q == '0);
        almost_full  = (level_q >= LvlAf);
        almost_empty = (level_q <= LvlAe);
        in_ready     = !full;
        out_valid    = !empty;
        out_data     = out_valid ? ram_rdata : '0;
        level        = level_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
        wr_fire      = in_valid && in_ready;
        rd_fire      = out_valid && out_ready;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_fire, rd_fire})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end

        // A fresh error event outranks a same-cycle clear.
        overflow_d  = err_clr ? 1'b0 : overflow_q;
        underflow_d = err_clr ? 1'b0 : underflow_q;
        if (in_valid && full)   overflow_d  = 1'b1;
        if (out_ready && empty) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .DATA_SIZE    (DATA_SIZE),
        .ADDRESS_SIZE (ADDRESS_SIZE)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire && !flush),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_fifo_stream.sv
// Bench for fifo_stream: directed scenarios plus random traffic checked against a queue model.
module tb_fifo_stream;

    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       err_clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [3:0] level;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    always #5 clk = ~clk;

    fifo_stream dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .err_clr      (err_clr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all(input string ctx);
        int         n;
        logic [7:0] head;
        n    = mq.size();
        head = (n > 0) ? mq[0] : 8'h00;
        check({ctx, ".level"},        32'(level),        32'(n));
        check({ctx, ".full"},         32'(full),         32'(n == DEPTH));
        check({ctx, ".empty"},        32'(empty),        32'(n == 0));
        check({ctx, ".in_ready"},     32'(in_ready),     32'(n != DEPTH));
        check({ctx, ".out_valid"},    32'(out_valid),    32'(n != 0));
        check({ctx, ".out_data"},     32'(out_data),     32'(head));
        check({ctx, ".almost_full"},  32'(almost_full),  32'(n >= AF));
        check({ctx, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
        check({ctx, ".overflow"},     32'(overflow),     32'(m_ovf));
        check({ctx, ".underflow"},    32'(underflow),    32'(m_unf));
    endtask

    // One clock: drive inputs, advance model by the handshake rules, compare just after the edge.
    task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl,
                        input logic ec, input string ctx);
        int n;
        n = mq.size();
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        err_clr   = ec;
        @(posedge clk);
        #1;
        if (iv && n == DEPTH) m_ovf = 1'b1;
        else if (ec)          m_ovf = 1'b0;
        if (ordy && n == 0)   m_unf = 1'b1;
        else if (ec)          m_unf = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            if (ordy && n > 0) void'(mq.pop_front());
            if (iv && n < DEPTH) mq.push_back(d);
        end
        compare_all(ctx);
    endtask

    initial begin
        #12;
        rst = 1'b1;
        #1;
        compare_all("reset");

        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, "fill");
        check("fill_full_flag", 32'(full), 32'd1);

        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, "push_full");
        check("push_full_ovf", 32'(overflow), 32'd1);

        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", 32'(out_data), 32'h10 + 32'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain");
        end
        check("drain_empty", 32'(empty), 32'd1);

        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "underflow");
        check("underflow_set", 32'(underflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "err_clr");
        check("err_clr_ovf", 32'(overflow), 32'd0);

        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0, "refill");
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, "clr_vs_ovf");
        check("clr_vs_ovf_wins", 32'(overflow), 32'd1);

        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "to_level4");
        for (int i = 0; i < 20; i++) step(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0, 1'b0, "stream");
        check("stream_level", 32'(level), 32'd4);

        step(1'b1, 8'h9F, 1'b0, 1'b0, 1'b0, "to_level5");
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, "flush");
        check("flush_level", 32'(level), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "after_flush");

        for (int i = 0; i < 3000; i++) begin
            int         wbias;
            logic       iv, ordy, fl, ec;
            if (i == 1500) begin
                in_valid  = 1'b1;
                out_ready = 1'b1;
                #2;
                rst = 1'b0;
                #1;
                mq.delete();
                m_ovf = 1'b0;
                m_unf = 1'b0;
                compare_all("mid_reset");
                @(negedge clk);
                rst = 1'b1;
                #1;
            end
            wbias = ((i / 200) % 2 == 0) ? 3 : 1;
            iv    = ($urandom_range(0, 3) < wbias);
            ordy  = ($urandom_range(0, 3) >= wbias);
            fl    = ($urandom_range(0, 63) == 0);
            ec    = ($urandom_range(0, 31) == 0);
            step(iv, 8'($urandom), ordy, fl, ec, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
